st_output_fifo: RTL and testbench

- Avalon-ST 32-bit packet buffer placed directly downstream of the DSP streaming source port, before the HPS/DMA sink.
- Absorbs DMA backpressure bursts so the FIR/TEA pipeline is not stalled beat-by-beat.
- Checks input packet framing.
- Exposes fill level, almost-full and completed-packet count to CSR.

---
 rtl/st_output_fifo_if.sv | 14 +
 rtl/st_output_fifo.sv | 146 ++++++++++++++
 tb/tb_st_output_fifo.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/st_output_fifo_if.sv
// Avalon-ST beat link: data with packet framing and a ready/valid handshake.
// The master drives the beat, the slave answers with ready.
interface st_output_fifo_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              sop;
  logic              eop;
  logic              ready;

  modport master (output data, output valid, output sop, output eop, input ready);
  modport slave  (input data, input valid, input sop, input eop, output ready);
endinterface

// File: rtl/st_output_fifo.sv
// Avalon-ST packet buffer between the DSP streaming source and the HPS/DMA sink.
// First-word-fall-through storage of {eop, sop, data}, input framing checker,
// fill level / almost-full and delivered-packet count for the CSR block.
module st_output_fifo #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  st_output_fifo_if.slave          sink,
  st_output_fifo_if.master         source,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full,
  output logic [15:0]              pkt_count,
  output logic                     framing_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = DATA_W + 2;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          af_q, af_d;
  logic          in_pkt_q, in_pkt_d;
  logic          err_q, err_d;
  logic [15:0]   pkt_q, pkt_d;

  logic          full;
  logic          empty;
  logic          wr_en;
  logic          rd_en;
  logic [EW-1:0] rd_word;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == {LW{1'b0}});

  // Ready depends only on stored state (and is forced low during reset),
  // so there is no combinational path from the sink into the source.
  assign sink.ready = rst_n & ~full;

  // A beat offered during a flush is dropped; a read during a flush is moot.
  assign wr_en = sink.valid & sink.ready & ~clear;
  assign rd_en = source.valid & source.ready & ~clear;

  assign rd_word       = mem_q[rd_ptr_q];
  assign source.valid  = ~empty;
  assign source.data   = rd_word[DATA_W-1:0];
  assign source.sop    = rd_word[DATA_W];
  assign source.eop    = rd_word[DATA_W+1];

  assign level       = level_q;
  assign almost_full = af_q;
  assign pkt_count   = pkt_q;
  assign framing_err = err_q;

  // Next-state for pointers, occupancy, framing tracker and packet counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    in_pkt_d = in_pkt_q;
    err_d    = err_q;
    pkt_d    = pkt_q;
    if (clear) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      level_d  = {LW{1'b0}};
      in_pkt_d = 1'b0;
      err_d    = 1'b0;
      pkt_d    = 16'd0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_en, rd_en})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      // Framing: sop must open a packet, every other beat must be inside one.
      // Bad beats are flagged but still stored untouched.
      if (wr_en) begin
        if (sink.sop == in_pkt_q) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (sink.eop) begin
          in_pkt_d = 1'b0;
        end else if (sink.sop) begin
          in_pkt_d = 1'b1;
        end else begin
          in_pkt_d = in_pkt_q;
        end
      end else begin
        err_d    = err_q;
        in_pkt_d = in_pkt_q;
      end
      if (rd_en && rd_word[EW-1]) begin
        pkt_d = pkt_q + 16'd1;
      end else begin
        pkt_d = pkt_q;
      end
    end
    af_d = (level_d >= LW'(AF_LEVEL));
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      level_q  <= {LW{1'b0}};
      af_q     <= 1'b0;
      in_pkt_q <= 1'b0;
      err_q    <= 1'b0;
      pkt_q    <= 16'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      af_q     <= af_d;
      in_pkt_q <= in_pkt_d;
      err_q    <= err_d;
      pkt_q    <= pkt_d;
    end
  end

  // Beat storage; contents need no reset because level gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {sink.eop, sink.sop, sink.data};
    end
  end
endmodule

// File: tb/tb_st_output_fifo.sv
// Self-checking bench for st_output_fifo: a scoreboard model tracks the
// expected contents, level, packet count and framing flag from the stimulus.
module tb_st_output_fifo;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [4:0]  level;
  logic        almost_full;
  logic [15:0] pkt_count;
  logic        framing_err;

  st_output_fifo_if #(.DATA_W(32)) snk_if ();
  st_output_fifo_if #(.DATA_W(32)) src_if ();

  st_output_fifo #(.DATA_W(32), .DEPTH(16), .AF_LEVEL(12)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .sink(snk_if), .source(src_if),
    .level(level), .almost_full(almost_full),
    .pkt_count(pkt_count), .framing_err(framing_err)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_checks = 0;
  logic [33:0] exp_q[$];
  logic [33:0] head;
  bit          m_in_pkt = 1'b0;
  bit          m_err = 1'b0;
  logic [15:0] m_pkt = 16'd0;
  bit          pop_ok;
  bit          push_ok;

  // Scoreboard: compare the DUT against the model, then advance the model to
  // what the coming rising edge should do with the inputs now applied.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_in_pkt = 1'b0; m_err = 1'b0; m_pkt = 16'd0;
    end else begin
      n_checks++; if (src_if.valid !== (exp_q.size() != 0)) $display("FAIL sb_valid got %b want %b", src_if.valid, exp_q.size() != 0); else n_pass++;
      n_checks++; if (level !== 5'(exp_q.size())) $display("FAIL sb_level got %0d want %0d", level, exp_q.size()); else n_pass++;
      n_checks++; if (snk_if.ready !== (exp_q.size() < 16)) $display("FAIL sb_ready got %b want %b", snk_if.ready, exp_q.size() < 16); else n_pass++;
      pop_ok  = src_if.ready && (exp_q.size() != 0);
      push_ok = snk_if.valid && (exp_q.size() < 16);
      if (pop_ok) begin
        n_checks++;
        if ({src_if.eop, src_if.sop, src_if.data} !== exp_q[0])
          $display("FAIL sb_beat got %h want %h", {src_if.eop, src_if.sop, src_if.data}, exp_q[0]);
        else n_pass++;
      end
      if (clear) begin
        exp_q.delete();
        m_in_pkt = 1'b0; m_err = 1'b0; m_pkt = 16'd0;
      end else begin
        if (pop_ok) begin
          head = exp_q.pop_front();
          if (head[33]) m_pkt = m_pkt + 16'd1;
        end
        if (push_ok) begin
          if (snk_if.sop && m_in_pkt) m_err = 1'b1;
          if (!snk_if.sop && !m_in_pkt) m_err = 1'b1;
          if (snk_if.eop) m_in_pkt = 1'b0;
          else if (snk_if.sop) m_in_pkt = 1'b1;
          exp_q.push_back({snk_if.eop, snk_if.sop, snk_if.data});
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic s, input logic e);
    snk_if.data = d; snk_if.sop = s; snk_if.eop = e; snk_if.valid = 1'b1;
    @(posedge clk); #1;
    snk_if.valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && level !== 5'd0; k++) begin @(posedge clk); #1; end
    n_checks++; if (level !== 5'd0) $display("FAIL drain_timeout level %0d want 0", level); else n_pass++;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (snk_if.ready !== 1'b0) $display("FAIL rst_ready got %b want 0", snk_if.ready); else n_pass++;
    n_checks++; if (src_if.valid !== 1'b0) $display("FAIL rst_valid got %b want 0", src_if.valid); else n_pass++;
    n_checks++; if (level !== 5'd0) $display("FAIL rst_level got %0d want 0", level); else n_pass++;
    n_checks++; if (pkt_count !== 16'd0 || framing_err !== 1'b0 || almost_full !== 1'b0)
      $display("FAIL rst_csr got %h/%b/%b want 0/0/0", pkt_count, framing_err, almost_full); else n_pass++;
    @(posedge clk); #1; rst_n = 1'b1; #1;
    n_checks++; if (snk_if.ready !== 1'b1) $display("FAIL rst_ready_rel got %b want 1", snk_if.ready); else n_pass++;
  endtask

  task automatic test_single_packet();
    src_if.ready = 1'b1;
    snk_if.data = 32'h11; snk_if.sop = 1'b1; snk_if.eop = 1'b0; snk_if.valid = 1'b1; #1;
    n_checks++; if (src_if.valid !== 1'b0) $display("FAIL sp_no_bypass got %b want 0", src_if.valid); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (src_if.valid !== 1'b1 || src_if.data !== 32'h11) $display("FAIL sp_latency got %b/%h want 1/11", src_if.valid, src_if.data); else n_pass++;
    send(32'h22, 1'b0, 1'b0);
    send(32'h33, 1'b0, 1'b1);
    cycles(3);
    n_checks++; if (pkt_count !== 16'd1) $display("FAIL sp_pkt got %0d want 1", pkt_count); else n_pass++;
    n_checks++; if (level !== 5'd0) $display("FAIL sp_level got %0d want 0", level); else n_pass++;
    n_checks++; if (framing_err !== 1'b0) $display("FAIL sp_err got %b want 0", framing_err); else n_pass++;
  endtask

  task automatic test_fill();
    src_if.ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send(32'hA000 + 32'(i), i == 0, i == 15);
      n_checks++; if (almost_full !== (i + 1 >= 12)) $display("FAIL fill_af i=%0d got %b want %b", i, almost_full, i + 1 >= 12); else n_pass++;
    end
    n_checks++; if (level !== 5'd16) $display("FAIL fill_level got %0d want 16", level); else n_pass++;
    n_checks++; if (snk_if.ready !== 1'b0) $display("FAIL fill_ready got %b want 0", snk_if.ready); else n_pass++;
    send(32'hDEAD, 1'b1, 1'b1);
    n_checks++; if (level !== 5'd16) $display("FAIL fill_17th level %0d want 16", level); else n_pass++;
    src_if.ready = 1'b1;
    cycles(16);
    n_checks++; if (level !== 5'd0 || almost_full !== 1'b0) $display("FAIL fill_drain got %0d/%b want 0/0", level, almost_full); else n_pass++;
  endtask

  task automatic test_back_to_back();
    src_if.ready = 1'b0;
    for (int i = 0; i < 8; i++) send(32'h100 + 32'(i), i == 0, 1'b0);
    n_checks++; if (level !== 5'd8) $display("FAIL b2b_prefill got %0d want 8", level); else n_pass++;
    src_if.ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      send(32'h108 + 32'(k), 1'b0, k == 19);
      n_checks++; if (level !== 5'd8) $display("FAIL b2b_level k=%0d got %0d want 8", k, level); else n_pass++;
    end
    drain();
  endtask

  task automatic test_framing();
    src_if.ready = 1'b1;
    send(32'h200, 1'b1, 1'b0);
    send(32'h201, 1'b0, 1'b0);
    n_checks++; if (framing_err !== 1'b0) $display("FAIL frm_early got %b want 0", framing_err); else n_pass++;
    send(32'h202, 1'b1, 1'b0);
    n_checks++; if (framing_err !== 1'b1) $display("FAIL frm_double_sop got %b want 1", framing_err); else n_pass++;
    send(32'h203, 1'b0, 1'b1);
    cycles(3);
    n_checks++; if (framing_err !== 1'b1 || framing_err !== m_err) $display("FAIL frm_sticky got %b want 1", framing_err); else n_pass++;
    drain();
  endtask

  task automatic test_clear();
    src_if.ready = 1'b0;
    for (int i = 0; i < 5; i++) send(32'h300 + 32'(i), i == 0, 1'b0);
    n_checks++; if (level !== 5'd5) $display("FAIL clr_prefill got %0d want 5", level); else n_pass++;
    snk_if.data = 32'hBAD; snk_if.sop = 1'b1; snk_if.eop = 1'b1; snk_if.valid = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; snk_if.valid = 1'b0;
    n_checks++; if (level !== 5'd0 || src_if.valid !== 1'b0) $display("FAIL clr_empty got %0d/%b want 0/0", level, src_if.valid); else n_pass++;
    n_checks++; if (pkt_count !== 16'd0 || framing_err !== 1'b0) $display("FAIL clr_csr got %h/%b want 0/0", pkt_count, framing_err); else n_pass++;
    src_if.ready = 1'b1;
    cycles(3);
    n_checks++; if (src_if.valid !== 1'b0) $display("FAIL clr_dropped got %b want 0", src_if.valid); else n_pass++;
  endtask

  task automatic test_first_nosop();
    src_if.ready = 1'b1;
    send(32'h400, 1'b0, 1'b1);
    n_checks++; if (framing_err !== 1'b1) $display("FAIL nosop_err got %b want 1", framing_err); else n_pass++;
    cycles(2);
  endtask

  task automatic test_pkt_wrap();
    clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
    src_if.ready = 1'b1;
    for (int i = 0; i < 65535; i++) send(32'(i), 1'b1, 1'b1);
    cycles(2);
    n_checks++; if (pkt_count !== 16'hFFFF) $display("FAIL wrap_max got %h want ffff", pkt_count); else n_pass++;
    send(32'h5A5A, 1'b1, 1'b1);
    cycles(2);
    n_checks++; if (pkt_count !== 16'h0000) $display("FAIL wrap_zero got %h want 0000", pkt_count); else n_pass++;
    n_checks++; if (framing_err !== 1'b0) $display("FAIL wrap_err got %b want 0", framing_err); else n_pass++;
  endtask

  task automatic test_reset_midpkt();
    src_if.ready = 1'b1;
    send(32'h500, 1'b1, 1'b1);
    cycles(2);
    src_if.ready = 1'b0;
    send(32'h600, 1'b0, 1'b0);
    send(32'h601, 1'b1, 1'b0);
    send(32'h602, 1'b0, 1'b0);
    send(32'h603, 1'b0, 1'b0);
    n_checks++; if (level !== 5'd4 || framing_err !== 1'b1 || pkt_count !== 16'd1)
      $display("FAIL rmp_pre got %0d/%b/%0d want 4/1/1", level, framing_err, pkt_count); else n_pass++;
    #2; rst_n = 1'b0; #1;
    n_checks++; if (level !== 5'd0 || src_if.valid !== 1'b0 || snk_if.ready !== 1'b0)
      $display("FAIL rmp_async got %0d/%b/%b want 0/0/0", level, src_if.valid, snk_if.ready); else n_pass++;
    n_checks++; if (pkt_count !== 16'd0 || framing_err !== 1'b0 || almost_full !== 1'b0)
      $display("FAIL rmp_csr got %h/%b/%b want 0/0/0", pkt_count, framing_err, almost_full); else n_pass++;
    @(posedge clk); #1; rst_n = 1'b1;
    src_if.ready = 1'b1;
    send(32'h700, 1'b1, 1'b0);
    n_checks++; if (framing_err !== 1'b0) $display("FAIL rmp_inpkt got %b want 0", framing_err); else n_pass++;
    send(32'h701, 1'b0, 1'b1);
    cycles(2);
    n_checks++; if (pkt_count !== 16'd1) $display("FAIL rmp_pkt got %0d want 1", pkt_count); else n_pass++;
  endtask

  initial begin
    snk_if.valid = 1'b0; snk_if.data = 32'd0; snk_if.sop = 1'b0; snk_if.eop = 1'b0;
    src_if.ready = 1'b0;
    test_reset();
    test_single_packet();
    test_fill();
    test_back_to_back();
    test_framing();
    test_clear();
    test_first_nosop();
    test_pkt_wrap();
    test_reset_midpkt();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
